// File: rtl/lshift_rotate_reg.sv
`default_nettype none
// ============================================================================
// Module   : lshift_rotate_reg
// Brief    : Parallel-loadable left shifter with optional MSB-to-LSB wrap.
// Revision : 1.0
// ============================================================================
module lshift_rotate_reg #(
    parameter int WIDTH  = 8,
    parameter bit ROTATE = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_en,
    output logic [WIDTH-1:0] op
);

    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] op_d;
    logic [WIDTH-1:0] shifted;

    // Only the LSB fill bit differs between the two modes.
    generate
        if (ROTATE) begin : g_rotate
            assign shifted = {op_q[WIDTH-2:0], op_q[WIDTH-1]};
        end else begin : g_logical
            assign shifted = {op_q[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        op_d = shifted;
        if (load_en) begin
            op_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q <= '0;
        end else begin
            op_q <= op_d;
        end
    end

    assign op = op_q;

endmodule
`default_nettype wire

// File: tb/tb_lshift_rotate_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_lshift_rotate_reg
// Brief    : Self-checking bench for rotate (ROTATE=1) and shift (ROTATE=0) builds.
// Revision : 1.0
// ============================================================================
module tb_lshift_rotate_reg;

    localparam int WIDTH = 8;

    typedef struct {
        bit         le;
        logic [7:0] lv;
        logic [7:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [WIDTH-1:0] load_val;
    logic             load_en;
    logic [WIDTH-1:0] op_rot;
    logic [WIDTH-1:0] op_lsl;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    lshift_rotate_reg #(.WIDTH(WIDTH), .ROTATE(1'b1)) u_rot (
        .clk      (clk),
        .rstn     (rstn),
        .load_val (load_val),
        .load_en  (load_en),
        .op       (op_rot)
    );

    lshift_rotate_reg #(.WIDTH(WIDTH), .ROTATE(1'b0)) u_lsl (
        .clk      (clk),
        .rstn     (rstn),
        .load_val (load_val),
        .load_en  (load_en),
        .op       (op_lsl)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, queue the expected value, then sample 1 time unit
    // after the capturing edge and compare against the popped expectation.
    task automatic step(input string name, input bit le, input logic [7:0] lv,
                        input logic [7:0] exp, input bit use_lsl);
        logic [7:0] e;
        @(negedge clk);
        load_en  = le;
        load_val = lv;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(name, use_lsl ? op_lsl : op_rot, e);
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        // Walking one: 1 load + 19 shifts, then one more shift to reach 0x10.
        v = '{le: 1'b1, lv: 8'h01, exp: 8'h01};
        vecs.push_back(v);
        for (int k = 1; k <= 20; k++) begin
            v = '{le: 1'b0, lv: 8'h00, exp: 8'h01 << (k % 8)};
            vecs.push_back(v);
        end
        // Load beats shift at 0x10, then rotate the loaded word.
        vecs.push_back('{le: 1'b1, lv: 8'hA5, exp: 8'hA5});
        vecs.push_back('{le: 1'b0, lv: 8'h00, exp: 8'h4B});
        vecs.push_back('{le: 1'b0, lv: 8'h00, exp: 8'h96});
        vecs.push_back('{le: 1'b0, lv: 8'h00, exp: 8'h2D});
        // Continuous load, all-ones, and MSB wrap.
        vecs.push_back('{le: 1'b1, lv: 8'h11, exp: 8'h11});
        vecs.push_back('{le: 1'b1, lv: 8'h22, exp: 8'h22});
        vecs.push_back('{le: 1'b1, lv: 8'h33, exp: 8'h33});
        vecs.push_back('{le: 1'b1, lv: 8'hFF, exp: 8'hFF});
        vecs.push_back('{le: 1'b0, lv: 8'h00, exp: 8'hFF});
        vecs.push_back('{le: 1'b0, lv: 8'h00, exp: 8'hFF});
        vecs.push_back('{le: 1'b1, lv: 8'h81, exp: 8'h81});
        vecs.push_back('{le: 1'b0, lv: 8'h00, exp: 8'h03});

        // Reset with load data present but no load.
        rstn     = 1'b0;
        load_en  = 1'b0;
        load_val = 8'h01;
        #1;
        check("reset_async_rot", op_rot, 8'h00);
        check("reset_async_lsl", op_lsl, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_rot", op_rot, 8'h00);
        check("reset_hold_lsl", op_lsl, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step("post_reset_zero", 1'b0, 8'h01, 8'h00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].le, vecs[i].lv, vecs[i].exp, 1'b0);
        end

        // Async reset between edges while op = 0x08, with a pending load.
        step("mid_load",   1'b1, 8'h01, 8'h01, 1'b0);
        step("mid_sh1",    1'b0, 8'h00, 8'h02, 1'b0);
        step("mid_sh2",    1'b0, 8'h00, 8'h04, 1'b0);
        step("mid_sh3",    1'b0, 8'h00, 8'h08, 1'b0);
        #3;
        rstn     = 1'b0;
        load_en  = 1'b1;
        load_val = 8'h55;
        #1;
        check("mid_reset_async", op_rot, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("mid_reset_hold_load", op_rot, 8'h00);
        end
        @(negedge clk);
        rstn    = 1'b1;
        load_en = 1'b0;
        step("after_release0", 1'b0, 8'h55, 8'h00, 1'b0);
        step("after_release1", 1'b0, 8'h55, 8'h00, 1'b0);
        step("reload_after",   1'b1, 8'h40, 8'h40, 1'b0);
        step("wrap_pre",       1'b0, 8'h00, 8'h80, 1'b0);
        step("wrap_msb",       1'b0, 8'h00, 8'h01, 1'b0);

        // Logical-shift build: 0x81 drains to zero and stays there.
        step("lsl_load", 1'b1, 8'h81, 8'h81, 1'b1);
        for (int k = 1; k <= 7; k++) step("lsl_shift", 1'b0, 8'h00, 8'h01 << k, 1'b1);
        for (int k = 0; k < 3; k++)  step("lsl_zero",  1'b0, 8'h00, 8'h00, 1'b1);
        step("lsl_reload", 1'b1, 8'h40, 8'h40, 1'b1);
        step("lsl_msb_discard_pre", 1'b0, 8'h00, 8'h80, 1'b1);
        step("lsl_msb_discard",     1'b0, 8'h00, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
